fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the ALU control decoder. Keeps the program counter and issues word fetches to instruction memory over a req/ack handshake. Registers each returned instruction with its PC and presents it to decode under a valid/stall handshake. Handles redirects from branch and jump resolution, including squashing a fetch that is still in flight.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake, and presents each returned instruction with its PC to decode
// under a valid/stall handshake. A one-entry skid absorbs an ack that lands
// while decode is stalled, and redirects squash any in-flight fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_instr_valid,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] addr;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_valid;

    logic        slot_free;
    logic [31:0] redir_tgt;

    // Decode can take a new word this cycle if the slot is empty or drains now.
    assign slot_free = !valid || !i_stall;
    assign redir_tgt = i_redirect_pc & 32'hFFFF_FFFC;

    // Request is a pure decode of the state flop, so it never depends on
    // same-cycle inputs; only HOLD (skid full) parks the memory port.
    assign o_imem_req    = (state != HOLD);
    assign o_imem_addr   = addr;
    assign o_instr       = instr;
    assign o_pc          = pc;
    assign o_instr_valid = valid;

    // Fetch control, output slot and skid; redirect outranks every other event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= FETCH;
            addr       <= {RESET_PC[31:2], 2'b00};
            target     <= 32'h0;
            instr      <= NOP;
            pc         <= 32'h0;
            valid      <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            skid_valid <= 1'b0;
        end else begin
            // Consumption empties the slot unless something refills it below.
            if (valid && !i_stall)
                valid <= 1'b0;

            if (i_redirect) begin
                valid      <= 1'b0;
                skid_valid <= 1'b0;
                case (state)
                    FETCH: begin
                        if (i_imem_ack) begin
                            // Request completed this cycle: drop it and go.
                            addr <= redir_tgt;
                        end else begin
                            // Address must stay put until the stale ack shows up.
                            target <= redir_tgt;
                            state  <= DISCARD;
                        end
                    end
                    HOLD: begin
                        addr  <= redir_tgt;
                        state <= FETCH;
                    end
                    DISCARD: begin
                        // Newest redirect wins; still owe the memory one ack.
                        target <= redir_tgt;
                    end
                    default: begin
                        addr  <= redir_tgt;
                        state <= FETCH;
                    end
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (i_imem_ack) begin
                            addr <= addr + 32'd4;
                            if (slot_free) begin
                                instr <= i_imem_rdata;
                                pc    <= addr;
                                valid <= 1'b1;
                            end else begin
                                skid_instr <= i_imem_rdata;
                                skid_pc    <= addr;
                                skid_valid <= 1'b1;
                                state      <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (slot_free && skid_valid) begin
                            instr      <= skid_instr;
                            pc         <= skid_pc;
                            valid      <= 1'b1;
                            skid_valid <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                    DISCARD: begin
                        if (i_imem_ack) begin
                            addr  <= target;
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run. A
// memory model answers requests after a fixed or random number of wait
// states with data = addr ^ KEY; the reference model is simply the expected
// program-order PC stream (advance by 4 per consumed instruction, jump on
// redirect), plus handshake rules on the memory port.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_instr_valid;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_instr_valid (o_instr_valid),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks   = 0;
    int          failures = 0;
    int          consumed = 0;
    int          fixed_wait = 0;
    int          wait_max   = 3;
    int          ws = 0;
    logic        pending = 1'b0;
    logic        redir_prev = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] exp_pc = RST_PC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
        chk({tag, "_instr"}, o_instr, 32'h0000_0013);
        chk({tag, "_pc"},    o_pc, 32'h0);
        chk({tag, "_req"},   32'(o_imem_req), 32'd1);
        chk({tag, "_addr"},  o_imem_addr, RST_PC);
    endtask

    // One clock cycle, entered and left at a falling edge. Observes the
    // current cycle's outputs, plays memory, updates the reference stream,
    // drives inputs, then advances one cycle.
    task automatic tick(input logic stall, input logic redir, input logic [31:0] rpc);
        logic ack;
        ack = 1'b0;
        if (redir_prev)
            chk("valid_after_redirect", 32'(o_instr_valid), 32'd0);
        redir_prev = redir;
        chk("addr_align", 32'(o_imem_addr[1:0]), 32'd0);
        chk("pc_align", 32'(o_pc[1:0]), 32'd0);
        if (pending && !o_imem_req)
            chk("req_dropped_early", 32'(o_imem_req), 32'd1);
        if (o_imem_req) begin
            if (!pending) begin
                pending  = 1'b1;
                req_addr = o_imem_addr;
                ws = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(wait_max, 0));
            end else begin
                chk("addr_stable", o_imem_addr, req_addr);
            end
            if (ws == 0) begin
                ack     = 1'b1;
                pending = 1'b0;
            end else begin
                ws--;
            end
        end
        if (o_instr_valid && !stall) begin
            chk("stream_pc", o_pc, exp_pc);
            chk("stream_instr", o_instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (redir)
            exp_pc = rpc & 32'hFFFF_FFFC;
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_ack    = ack;
        i_imem_rdata  = ack ? (o_imem_addr ^ KEY) : $urandom();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_imem_ack    = 1'b0;
        i_imem_rdata  = 32'h0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        pending    = 1'b0;
        redir_prev = 1'b0;
        exp_pc     = RST_PC;
    endtask

    initial begin
        int c0;
        logic [31:0] rpc;

        // Reset values
        do_reset();
        chk_reset_vals("rst");

        // Zero-wait memory: one instruction per cycle, valid held high
        fixed_wait = 0;
        tick(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("zw_valid", 32'(o_instr_valid), 32'd1);
            chk("zw_pc", o_pc, RST_PC + 32'(4 * i));
            tick(1'b0, 1'b0, 32'h0);
        end

        // Three wait states: one instruction every four cycles
        do_reset();
        fixed_wait = 3;
        c0 = consumed;
        for (int i = 0; i < 40; i++)
            tick(1'b0, 1'b0, 32'h0);
        chk("w3_rate", 32'(consumed - c0), 32'd9);

        // Stall with a new ack arriving: skid absorbs it, req parks
        do_reset();
        fixed_wait = 0;
        tick(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            chk("hold_req", 32'(o_imem_req), 32'd0);
            chk("hold_pc", o_pc, RST_PC);
            chk("hold_valid", 32'(o_instr_valid), 32'd1);
        end
        tick(1'b0, 1'b0, 32'h0);
        chk("skid_pc", o_pc, RST_PC + 32'd4);
        tick(1'b0, 1'b0, 32'h0);
        chk("after_skid_pc", o_pc, RST_PC + 32'd8);

        // Redirect while a request is outstanding
        do_reset();
        fixed_wait = 2;
        tick(1'b0, 1'b1, 32'h0000_2002);
        chk("disc_addr_held", o_imem_addr, RST_PC);
        chk("disc_req", 32'(o_imem_req), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("disc_new_addr", o_imem_addr, 32'h0000_2000);
        c0 = consumed;
        for (int i = 0; i < 10; i++)
            tick(1'b0, 1'b0, 32'h0);
        chk("disc_deliver", 32'(consumed > c0), 32'd1);

        // Redirect coincident with ack, then a second one during DISCARD
        do_reset();
        fixed_wait = 2;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_2000);
        chk("coinc_addr", o_imem_addr, 32'h0000_2000);
        tick(1'b0, 1'b1, 32'h0000_2800);
        tick(1'b0, 1'b1, 32'h0000_3000);
        tick(1'b0, 1'b0, 32'h0);
        chk("latest_target", o_imem_addr, 32'h0000_3000);
        c0 = consumed;
        for (int i = 0; i < 10; i++)
            tick(1'b0, 1'b0, 32'h0);
        chk("latest_deliver", 32'(consumed > c0), 32'd1);

        // PC wrap at the top of the address space
        do_reset();
        fixed_wait = 0;
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk("wrap_addr1", o_imem_addr, 32'h0000_0000);
        chk("wrap_pc0", o_pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", o_pc, 32'h0000_0000);

        // Reset pulsed mid-request; an ack during reset is ignored
        fixed_wait = 3;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        #2 i_rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        @(posedge i_clk);
        #1 chk_reset_vals("rst_ack");
        @(negedge i_clk);
        i_imem_ack = 1'b0;
        i_rst_n    = 1'b1;
        pending    = 1'b0;
        redir_prev = 1'b0;
        exp_pc     = RST_PC;
        chk("restart_addr", o_imem_addr, RST_PC);
        c0 = consumed;
        for (int i = 0; i < 20; i++)
            tick(1'b0, 1'b0, 32'h0);
        chk("restart_deliver", 32'(consumed > c0), 32'd1);

        // Randomized traffic: random waits, stalls and redirects
        do_reset();
        fixed_wait = -1;
        wait_max   = 3;
        c0 = consumed;
        for (int i = 0; i < 2000; i++) begin
            rpc = ($urandom_range(1, 0) == 0) ? $urandom()
                                              : (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)));
            tick($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, rpc);
        end
        chk("rand_progress", 32'(consumed - c0 > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
